// File: rtl/uart_rx_cfg_if.sv
// Received-word channel of the configurable UART receiver: data, valid/ready
// handshake and the per-word error flags that travel with the data.
interface uart_rx_cfg_if #(
  parameter int MAX_DATA_W = 9
);
  logic [MAX_DATA_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;

  // Producer side (the receiver).
  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  // Consumer side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable oversampling UART receiver. The frame format
// (5..MAX_DATA_W data bits, optional even/odd parity, 1 or 2 stop bits) is
// captured at start detection. Each bit is decided by a 3-sample majority
// vote around mid-bit. Words are offered on a valid/ready channel; a word that
// completes while the previous one is still unconsumed is dropped with a
// one-cycle overrun pulse.
module uart_rx_cfg #(
  parameter int MAX_DATA_W  = 9,
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick_i,
  input  logic       rxd_i,
  input  logic [3:0] cfg_data_len_i,
  input  logic       cfg_parity_en_i,
  input  logic       cfg_parity_even_i,
  input  logic [1:0] cfg_stop_len_i,
  uart_rx_cfg_if.master rx_if,
  output logic       overrun_err_o,
  output logic       busy_o
);

  localparam int              CNT_W    = $clog2(OSR);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OSR - 1);
  localparam logic [3:0]      MIN_LEN  = 4'd5;
  localparam logic [3:0]      MAX_LEN  = 4'(MAX_DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for the given data XOR.
  function automatic logic exp_parity(input logic data_xor, input logic even);
    return data_xor ^ ~even;
  endfunction

  // Legal data length range is 5..MAX_DATA_W; anything outside is pinned.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    logic [3:0] r;
    if (len < MIN_LEN) begin
      r = MIN_LEN;
    end else if (len > MAX_LEN) begin
      r = MAX_LEN;
    end else begin
      r = len;
    end
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [MAX_DATA_W-1:0]  data_q, data_d;
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [3:0]             len_q, len_d;
  logic                   par_en_q, par_en_d;
  logic                   par_even_q, par_even_d;
  logic                   stop2_q, stop2_d;
  logic [MAX_DATA_W-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_perr_q, out_perr_d;
  logic                   out_ferr_q, out_ferr_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
  logic                   rxd_s;
  logic                   vote_s;
  logic                   frame_done_s;
  logic                   load_s;

  assign rxd_s  = sync_q[SYNC_STAGES-1];
  // hist_q[1:0] hold the two previous tick samples; with the current one
  // they form the vote window.
  assign vote_s = maj3(hist_q[1], hist_q[0], rxd_s);

  // Synchroniser shift and per-tick sample history.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd_i};
    if (baud_tick_i) begin
      hist_d = {hist_q[0], rxd_s};
    end else begin
      hist_d = hist_q;
    end
  end

  // Frame FSM: start detection, bit voting, parity and stop checking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    data_d       = data_q;
    par_d        = par_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_even_d   = par_even_q;
    stop2_d      = stop2_q;
    frame_done_s = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s && hist_q[0]) begin
            state_d    = S_START;
            cnt_d      = '0;
            bit_d      = 4'd0;
            data_d     = '0;
            par_d      = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            len_d      = clamp_len(cfg_data_len_i);
            par_en_d   = cfg_parity_en_i;
            par_even_d = cfg_parity_even_i;
            stop2_d    = (cfg_stop_len_i != 2'd0);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          // The detection tick is sample 0, so this vote lands at mid start bit.
          if (cnt_q == HALF_CNT) begin
            cnt_d   = '0;
            state_d = vote_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d         = '0;
            data_d[bit_q] = vote_s;
            par_d         = par_q ^ vote_s;
            if (bit_q == (len_q - 4'd1)) begin
              bit_d   = 4'd0;
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            perr_d  = vote_s ^ exp_parity(par_q, par_even_q);
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            ferr_d = ferr_q | ~vote_s;
            // Leave at mid stop bit so a back-to-back start edge is caught.
            if (bit_q == {3'b000, stop2_q}) begin
              bit_d        = 4'd0;
              state_d      = S_IDLE;
              frame_done_s = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output word register with valid/ready handshake and overrun detection.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    overrun_d   = 1'b0;
    busy_d      = (state_d != S_IDLE);
    load_s      = frame_done_s & (~out_valid_q | rx_if.rx_ready);
    if (load_s) begin
      out_data_d  = data_q;
      out_perr_d  = perr_q;
      out_ferr_d  = ferr_d;
      out_valid_d = 1'b1;
    end else if (frame_done_s) begin
      // Previous word still pending and not accepted: drop the new one.
      overrun_d = 1'b1;
    end else if (out_valid_q && rx_if.rx_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State register for front end, FSM datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      hist_q      <= 2'b11;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      data_q      <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      len_q       <= MIN_LEN;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      stop2_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      par_q       <= par_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      len_q       <= len_d;
      par_en_q    <= par_en_d;
      par_even_q  <= par_even_d;
      stop2_q     <= stop2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.rx_data    = out_data_q;
  assign rx_if.rx_valid   = out_valid_q;
  assign rx_if.parity_err = out_perr_q;
  assign rx_if.frame_err  = out_ferr_q;
  assign overrun_err_o    = overrun_q;
  assign busy_o           = busy_q;

endmodule
